// File: rtl/scr1_tb_ahb_pkg.sv
// Shared types and AHB-Lite encodings for the testbench memory slave port.
// Byte-enable helper is shared so every port computes lanes the same way.
package scr1_tb_ahb_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_FIXED  = 2'd1,
    STALL_RANDOM = 2'd2,
    STALL_RSVD   = 2'd3
  } stall_mode_e;

  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_tb_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping only when adv is high.
// The polynomial is primitive, so a non-zero seed never reaches the all-zero state.
module scr1_tb_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: shift left, feedback from taps 8,6,5,4
  always_comb begin
    value_d = value_q;
    if (adv) begin
      value_d = {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
    end else begin
      value_d = value_q;
    end
  end

  // LFSR register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/scr1_tb_ahb_slave_port.sv
// AHB-Lite slave front-end for the testbench memory: decodes address/data phases,
// inserts wait states, issues one memory access per transfer, returns ERROR on illegal ones.
module scr1_tb_ahb_slave_port
  import scr1_tb_ahb_pkg::*;
#(
  parameter int unsigned SCR1_MEM_POWER_SIZE = 20,
  parameter logic [7:0]  SCR1_LFSR_SEED      = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     stall_mode_in,
  input  logic [3:0]                     stall_cycles_in,
  input  logic [2:0]                     hsize,
  input  logic [1:0]                     htrans,
  input  logic [SCR1_AHB_WIDTH-1:0]      haddr,
  input  logic                           hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0]      hwdata,
  output logic                           hready,
  output logic [SCR1_AHB_WIDTH-1:0]      hrdata,
  output logic                           hresp,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [SCR1_MEM_POWER_SIZE-1:0] mem_addr,
  output logic [3:0]                     mem_be,
  output logic [SCR1_AHB_WIDTH-1:0]      mem_wdata,
  input  logic [SCR1_AHB_WIDTH-1:0]      mem_rdata
);

  slv_state_e                     state_q, state_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           wr_q, wr_d;
  logic [SCR1_MEM_POWER_SIZE-1:0] addr_q, addr_d;
  logic [3:0]                     be_q, be_d;

  logic       accept_s;
  logic       final_s;
  logic       capture_s;
  logic       err_s;
  logic [3:0] wait_s;
  logic [7:0] lfsr_val_s;
  logic       unused_bits_s;

  scr1_tb_lfsr8 #(
    .SEED (SCR1_LFSR_SEED)
  ) i_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (capture_s),
    .value (lfsr_val_s)
  );

  assign final_s   = (state_q == ST_DATA) && (cnt_q == 4'd0);
  assign accept_s  = (state_q == ST_IDLE) || final_s || (state_q == ST_ERR2);
  assign capture_s = accept_s && htrans[1];

  // Legality of the presented address phase, checked in priority order
  always_comb begin
    err_s = 1'b0;
    if (hsize > HSIZE_WORD) begin
      err_s = 1'b1;
    end else if (((hsize == HSIZE_HALF) && haddr[0]) ||
                 ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00))) begin
      err_s = 1'b1;
    end else if ((haddr >> SCR1_MEM_POWER_SIZE) != 32'd0) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Wait count sampled at capture; the reserved mode behaves like no stalls
  always_comb begin
    case (stall_mode_e'(stall_mode_in))
      STALL_FIXED:  wait_s = stall_cycles_in;
      STALL_RANDOM: wait_s = lfsr_val_s[3:0] & stall_cycles_in;
      default:      wait_s = 4'd0;
    endcase
  end

  // Next-state and transfer capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    case (state_q)
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_DATA, ST_IDLE, ST_ERR2: begin
        if ((state_q == ST_DATA) && (cnt_q != 4'd0)) begin
          cnt_d = cnt_q - 4'd1;
        end else if (capture_s) begin
          wr_d   = hwrite;
          addr_d = haddr[SCR1_MEM_POWER_SIZE-1:0];
          be_d   = ahb_byte_en(hsize, haddr[1:0]);
          if (err_s) begin
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_DATA;
            cnt_d   = wait_s;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Transfer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= {SCR1_MEM_POWER_SIZE{1'b0}};
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  assign hready    = (state_q != ST_ERR1) && !((state_q == ST_DATA) && (cnt_q != 4'd0));
  assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign mem_req   = final_s;
  assign mem_we    = final_s && wr_q;
  assign mem_addr  = addr_q;
  assign mem_be    = final_s ? be_q : 4'd0;
  assign mem_wdata = hwdata;
  // Read data is forwarded straight from the array in the completing cycle
  assign hrdata    = (final_s && !wr_q) ? mem_rdata : 32'd0;

  assign unused_bits_s = ^{lfsr_val_s[7:4], htrans[0]};

endmodule

// File: tb/tb_scr1_tb_ahb_slave_port.sv
// Self-checking bench: AHB master driver plus transaction-level reference model
// (word memory, LFSR sequence, wait counts) for scr1_tb_ahb_slave_port.
module tb_scr1_tb_ahb_slave_port;

  logic        clk;
  logic        rst_n;
  logic [1:0]  stall_mode_in;
  logic [3:0]  stall_cycles_in;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hresp;
  logic        mem_req;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  scr1_tb_ahb_slave_port #(
    .SCR1_MEM_POWER_SIZE (20),
    .SCR1_LFSR_SEED      (8'hA5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_mode_in   (stall_mode_in),
    .stall_cycles_in (stall_cycles_in),
    .hsize           (hsize),
    .htrans          (htrans),
    .haddr           (haddr),
    .hwrite          (hwrite),
    .hwdata          (hwdata),
    .hready          (hready),
    .hrdata          (hrdata),
    .hresp           (hresp),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory driven by the DUT, and a separate reference memory for expectations
  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  assign mem_rdata = env_mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_req && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) env_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic [3:0]  stall;
  } xfer_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  logic [7:0] m_lfsr;
  logic  p_valid;
  logic  p_err;
  int    p_wait;
  xfer_t p_x;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1: feedback is the XOR of the bits at exponents 8,6,5,4
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    int taps [4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[6:0], fb};
  endfunction

  function automatic xfer_t mk(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input logic [1:0] mode, input logic [3:0] stall);
    xfer_t x;
    x.trans = trans; x.wr = wr; x.addr = addr; x.size = size;
    x.wdata = wdata; x.mode = mode; x.stall = stall;
    return x;
  endfunction

  function automatic logic is_illegal(input xfer_t x);
    int bytes;
    if (x.size > 3'd2) return 1'b1;
    bytes = 1 << x.size;
    if ((x.addr % bytes) != 0) return 1'b1;
    return (x.addr >= 32'h0010_0000);
  endfunction

  function automatic logic [3:0] lanes(input xfer_t x);
    logic [3:0] be = 4'd0;
    for (int b = 0; b < (1 << x.size); b++) be[int'(x.addr[1:0]) + b] = 1'b1;
    return be;
  endfunction

  // One bus cycle group: present x as the address phase while finishing the pending data phase
  task automatic step(input xfer_t x);
    logic [3:0] be;
    htrans = x.trans; haddr = x.addr; hwrite = x.wr; hsize = x.size;
    stall_mode_in = x.mode; stall_cycles_in = x.stall;
    hwdata = p_valid ? p_x.wdata : $urandom;
    #1;
    if (p_valid && p_err) begin
      check_val("err1_hready", {31'd0, hready}, 32'd0);
      check_val("err1_hresp", {31'd0, hresp}, 32'd1);
      check_val("err1_mem_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); @(negedge clk); #1;
      check_val("err2_hready", {31'd0, hready}, 32'd1);
      check_val("err2_hresp", {31'd0, hresp}, 32'd1);
      check_val("err2_mem_req", {31'd0, mem_req}, 32'd0);
    end else if (p_valid) begin
      for (int k = 0; k < p_wait; k++) begin
        check_val("wait_hready", {31'd0, hready}, 32'd0);
        check_val("wait_hresp", {31'd0, hresp}, 32'd0);
        check_val("wait_mem_req", {31'd0, mem_req}, 32'd0);
        stall_mode_in = 2'($urandom); stall_cycles_in = 4'($urandom);
        @(posedge clk); @(negedge clk);
        stall_mode_in = x.mode; stall_cycles_in = x.stall;
        #1;
      end
      be = lanes(p_x);
      check_val("done_hready", {31'd0, hready}, 32'd1);
      check_val("done_hresp", {31'd0, hresp}, 32'd0);
      check_val("done_mem_req", {31'd0, mem_req}, 32'd1);
      check_val("done_mem_we", {31'd0, mem_we}, {31'd0, p_x.wr});
      check_val("done_mem_addr", {12'd0, mem_addr}, {12'd0, p_x.addr[19:0]});
      check_val("done_mem_be", {28'd0, mem_be}, {28'd0, be});
      check_val("done_hrdata", hrdata, p_x.wr ? 32'd0 : ref_mem[p_x.addr[11:2]]);
      if (p_x.wr) begin
        check_val("done_mem_wdata", mem_wdata, p_x.wdata);
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[p_x.addr[11:2]][8*b +: 8] = p_x.wdata[8*b +: 8];
      end
    end else begin
      check_val("idle_hready", {31'd0, hready}, 32'd1);
      check_val("idle_hresp", {31'd0, hresp}, 32'd0);
      check_val("idle_mem_req", {31'd0, mem_req}, 32'd0);
    end
    if (x.trans[1]) begin
      p_valid = 1'b1;
      p_err   = is_illegal(x);
      case (x.mode)
        2'd1:    p_wait = int'(x.stall);
        2'd2:    p_wait = int'(m_lfsr % 16) & int'(x.stall);
        default: p_wait = 0;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
      p_x = x;
    end else begin
      p_valid = 1'b0;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle_step();
    step(mk(2'd0, 1'b0, 32'd0, 3'd2, 32'd0, 2'd0, 4'd0));
  endtask

  initial begin
    logic [31:0] saved;
    xfer_t x;
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    rst_n = 1'b0; htrans = 2'd0; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd2;
    hwdata = 32'd0; stall_mode_in = 2'd0; stall_cycles_in = 4'd0;
    m_lfsr = 8'hA5; p_valid = 1'b0; p_err = 1'b0; p_wait = 0; p_x = '0;
    repeat (2) @(negedge clk);
    check_val("rst_hready", {31'd0, hready}, 32'd1);
    check_val("rst_hresp", {31'd0, hresp}, 32'd0);
    check_val("rst_hrdata", hrdata, 32'd0);
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_mem_be", {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write then read-back
    step(mk(2'd2, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 2'd0, 4'd0));
    step(mk(2'd2, 1'b0, 32'h100, 3'd2, 32'h0, 2'd0, 4'd0));
    idle_step();
    // Fixed three-cycle stall on a read
    step(mk(2'd2, 1'b0, 32'h100, 3'd2, 32'h0, 2'd1, 4'd3));
    idle_step();
    // Byte and halfword lanes
    step(mk(2'd2, 1'b1, 32'h103, 3'd0, 32'hAB00_0000, 2'd0, 4'd0));
    step(mk(2'd2, 1'b1, 32'h102, 3'd1, 32'h1234_0000, 2'd0, 4'd0));
    step(mk(2'd2, 1'b0, 32'h100, 3'd2, 32'h0, 2'd0, 4'd0));
    // Out-of-range and misaligned accesses
    step(mk(2'd2, 1'b0, 32'h0010_0000, 3'd2, 32'h0, 2'd0, 4'd0));
    step(mk(2'd2, 1'b0, 32'h2, 3'd2, 32'h0, 2'd0, 4'd0));
    idle_step();
    // Pseudo-random stalls with BUSY cycles interleaved
    for (int i = 0; i < 16; i++) begin
      step(mk(2'd2, i[0], 32'h200 + 32'(i * 4), 3'd2, $urandom, 2'd2, 4'hF));
      if (i % 3 == 1) step(mk(2'd1, 1'b0, 32'h0, 3'd2, 32'h0, 2'd2, 4'hF));
    end
    idle_step();

    // Reset while a write is two cycles from completing
    saved = env_mem[32'h300 >> 2];
    htrans = 2'd2; haddr = 32'h300; hwrite = 1'b1; hsize = 3'd2;
    stall_mode_in = 2'd1; stall_cycles_in = 4'd5;
    @(posedge clk); @(negedge clk);
    htrans = 2'd0; hwdata = ~saved;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre_rst_hready", {31'd0, hready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("abort_hready", {31'd0, hready}, 32'd1);
    check_val("abort_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("abort_hresp", {31'd0, hresp}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_val("abort_no_write", env_mem[32'h300 >> 2], saved);
    m_lfsr = 8'hA5; p_valid = 1'b0;
    step(mk(2'd2, 1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 2'd0, 4'd0));
    step(mk(2'd2, 1'b0, 32'h100, 3'd2, 32'h0, 2'd0, 4'd0));

    // Random mix of transfers, stall modes, sizes and illegal addresses
    for (int i = 0; i < 80; i++) begin
      x.trans = 2'($urandom);
      x.wr    = 1'($urandom);
      x.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      x.addr  = {20'd0, 12'($urandom)};
      if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
      if ($urandom_range(0, 9) == 0) x.addr = x.addr | (32'd1 << $urandom_range(20, 31));
      x.wdata = $urandom;
      x.mode  = 2'($urandom);
      x.stall = 4'($urandom);
      step(x);
    end
    idle_step();
    idle_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
